// File: rtl/dma.sv
// Single-channel word-copy DMA engine: a register slave port for setup and a
// bus master that moves one word per bus tenure from SRC to DST.
module dma (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [1:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_,
    output logic        irq,
    output logic        bus_req_,
    input  logic        bus_grnt_,
    output logic [29:0] bus_addr,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_RD      = 3'd2,
        S_RD_WAIT = 3'd3,
        S_WR      = 3'd4,
        S_WR_WAIT = 3'd5,
        S_RELEASE = 3'd6
    } state_t;

    localparam logic [1:0] A_CTRL  = 2'd0;
    localparam logic [1:0] A_SRC   = 2'd1;
    localparam logic [1:0] A_DST   = 2'd2;
    localparam logic [1:0] A_COUNT = 2'd3;

    state_t      state_q, state_d;
    logic [29:0] src_q, src_d;
    logic [29:0] dst_q, dst_d;
    logic [15:0] count_q, count_d;
    logic [31:0] buf_q, buf_d;
    logic        ie_q, ie_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;
    logic        irq_q, irq_d;
    logic        rdy_q, rdy_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [29:0] bus_addr_q, bus_addr_d;
    logic        bus_rw_q, bus_rw_d;
    logic [31:0] bus_wr_data_q, bus_wr_data_d;

    logic        slv_access;
    logic        slv_wr;
    logic        ctrl_wr;
    logic        busy;
    logic        start;
    logic        count_zero;
    logic        wr_data_unused;

    assign slv_access     = ~cs_ & ~as_;
    assign slv_wr         = slv_access & ~rw;
    assign ctrl_wr        = slv_wr && (addr == A_CTRL);
    assign busy           = (state_q != S_IDLE);
    assign start          = ctrl_wr & wr_data[0] & ~busy;
    assign count_zero     = (count_q == 16'd0);
    assign wr_data_unused = &{1'b0, wr_data[31:30]};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a pending abort is honoured only at REQ or RELEASE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !count_zero) state_d = S_REQ;
            end
            S_REQ: begin
                if (abort_q)         state_d = S_IDLE;
                else if (!bus_grnt_) state_d = S_RD;
            end
            S_RD: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (!bus_rdy_) state_d = S_WR;
            end
            S_WR: begin
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (!bus_rdy_) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (abort_q || count_zero) state_d = S_IDLE;
                else                       state_d = S_REQ;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        bus_as_  = 1'b1;
        bus_req_ = 1'b1;
        case (state_q)
            S_REQ: begin
                bus_req_ = abort_q;
            end
            S_RD, S_WR: begin
                bus_as_  = 1'b0;
                bus_req_ = 1'b0;
            end
            S_RD_WAIT, S_WR_WAIT: begin
                bus_req_ = 1'b0;
            end
            default: begin
                bus_as_  = 1'b1;
                bus_req_ = 1'b1;
            end
        endcase
    end

    // Register file, progress counters and master datapath
    always_comb begin
        src_d         = src_q;
        dst_d         = dst_q;
        count_d       = count_q;
        buf_d         = buf_q;
        ie_d          = ie_q;
        done_d        = done_q;
        abort_d       = abort_q;
        bus_addr_d    = bus_addr_q;
        bus_rw_d      = bus_rw_q;
        bus_wr_data_d = bus_wr_data_q;

        if (slv_wr && !busy) begin
            case (addr)
                A_SRC:   src_d   = wr_data[29:0];
                A_DST:   dst_d   = wr_data[29:0];
                A_COUNT: count_d = wr_data[15:0];
                default: ;
            endcase
        end

        if (ctrl_wr) begin
            ie_d = wr_data[1];
            if (wr_data[2])          done_d  = 1'b0;
            if (busy && !wr_data[0]) abort_d = 1'b1;
        end

        if (state_q == S_RD_WAIT && !bus_rdy_) begin
            buf_d = bus_rd_data;
        end

        if (state_q == S_WR_WAIT && !bus_rdy_) begin
            src_d   = src_q + 30'd1;
            dst_d   = dst_q + 30'd1;
            count_d = count_q - 16'd1;
        end

        // A set in the same cycle as a clear write must win
        if ((start && count_zero) ||
            (state_q == S_RELEASE && count_zero && !abort_q)) begin
            done_d = 1'b1;
        end

        if (state_d == S_IDLE) begin
            abort_d = 1'b0;
        end

        if (state_d == S_RD) begin
            bus_addr_d = src_q;
            bus_rw_d   = 1'b1;
        end else if (state_d == S_WR) begin
            bus_addr_d    = dst_q;
            bus_rw_d      = 1'b0;
            bus_wr_data_d = buf_d;
        end
    end

    // Slave response: registered so rdy_ and data appear the cycle after the strobe
    always_comb begin
        irq_d     = done_q & ie_q;
        rdy_d     = ~slv_access;
        rd_data_d = 32'd0;
        if (slv_access && rw) begin
            case (addr)
                A_CTRL:  rd_data_d = {29'd0, done_q, ie_q, busy};
                A_SRC:   rd_data_d = {2'd0, src_q};
                A_DST:   rd_data_d = {2'd0, dst_q};
                default: rd_data_d = {16'd0, count_q};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q         <= 30'd0;
            dst_q         <= 30'd0;
            count_q       <= 16'd0;
            buf_q         <= 32'd0;
            ie_q          <= 1'b0;
            done_q        <= 1'b0;
            abort_q       <= 1'b0;
            irq_q         <= 1'b0;
            rdy_q         <= 1'b1;
            rd_data_q     <= 32'd0;
            bus_addr_q    <= 30'd0;
            bus_rw_q      <= 1'b1;
            bus_wr_data_q <= 32'd0;
        end else begin
            src_q         <= src_d;
            dst_q         <= dst_d;
            count_q       <= count_d;
            buf_q         <= buf_d;
            ie_q          <= ie_d;
            done_q        <= done_d;
            abort_q       <= abort_d;
            irq_q         <= irq_d;
            rdy_q         <= rdy_d;
            rd_data_q     <= rd_data_d;
            bus_addr_q    <= bus_addr_d;
            bus_rw_q      <= bus_rw_d;
            bus_wr_data_q <= bus_wr_data_d;
        end
    end

    assign irq         = irq_q;
    assign rdy_        = rdy_q;
    assign rd_data     = rd_data_q;
    assign bus_addr    = bus_addr_q;
    assign bus_rw      = bus_rw_q;
    assign bus_wr_data = bus_wr_data_q;

endmodule
